// File: rtl/pwm_dac.sv
// pwm_dac: turns one WIDTH-bit sample per 2^WIDTH-cycle period into a registered PWM pin.
// Define PWM_DAC_DITHER_EN to add 1-LSB LFSR dither to every duty load.
module pwm_dac #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic [7:0]       underrun_count
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, duty_q, duty_d, shadow_q, shadow_d, load_val;
    logic             shadow_full_q, shadow_full_d, pwm_q, pwm_d, period_start_q, period_start_d;
    logic [7:0]       underrun_q, underrun_d;
    logic             accept, boundary, load;

    assign sample_ready   = !shadow_full_q && !rst;
    assign accept         = sample_valid && sample_ready;
    assign boundary       = (state_q == RUN) && (cnt_q == CNT_MAX);
    assign pwm_out        = pwm_q;
    assign period_start   = period_start_q;
    assign underrun_count = underrun_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shadow_d       = shadow_q;
        shadow_full_d  = shadow_full_q;
        underrun_d     = underrun_q;
        period_start_d = 1'b0;
        load           = 1'b0;
        load_val       = shadow_q;
        if (state_q == IDLE) begin
            if (accept) begin
                state_d        = RUN;
                load           = 1'b1;
                load_val       = sample_in;
                period_start_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
            if (boundary) begin
                period_start_d = 1'b1;
                if (shadow_full_q) begin
                    load          = 1'b1;
                    shadow_full_d = 1'b0;
                end else if (underrun_q != 8'hFF) begin
                    underrun_d = underrun_q + 8'd1;
                end
            end
            // a boundary-cycle accept lands in the shadow and waits a full period
            if (accept) begin
                shadow_d      = sample_in;
                shadow_full_d = 1'b1;
            end
        end
    end

`ifdef PWM_DAC_DITHER_EN
    logic [15:0]      lfsr_q, lfsr_d;
    logic [WIDTH-1:0] base_q, base_d;

    // base holds the undithered sample so repeated periods re-dither from scratch
    always_comb begin
        lfsr_d = boundary ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
        base_d = load ? load_val : base_q;
        duty_d = (load || boundary) ? ((base_d == CNT_MAX) ? base_d : base_d + WIDTH'(lfsr_q[0])) : duty_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
            base_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            base_q <= base_d;
        end
    end
`else
    assign duty_d = load ? load_val : duty_q;
`endif

    assign pwm_d = (state_d == RUN) && (cnt_d < duty_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            duty_q         <= '0;
            shadow_q       <= '0;
            shadow_full_q  <= 1'b0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            underrun_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            shadow_q       <= shadow_d;
            shadow_full_q  <= shadow_full_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            underrun_q     <= underrun_d;
        end
    end
endmodule
